// File: rtl/min_max_pkg.sv
// Shared types for the min/max LED-bar controller: datapath commands,
// controller states and edit-target selection.
package min_max_pkg;

  typedef logic [1:0] com_t;

  localparam com_t COM_RANGE  = 2'b00;
  localparam com_t COM_LINEAR = 2'b01;
  localparam com_t COM_OFF    = 2'b10;
  localparam com_t COM_ON     = 2'b11;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    EDIT   = 2'b01,
    COMMIT = 2'b10
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SEL_VAL  = 2'b00,
    SEL_MIN  = 2'b01,
    SEL_MAX  = 2'b10,
    SEL_NONE = 2'b11
  } sel_t;

endpackage

// File: rtl/osc_gen.sv
// Free-running blink generator: osc_o toggles every DIV clock cycles,
// giving a period of 2*DIV cycles.
module osc_gen #(
  parameter int DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic osc_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_osc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_osc <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_osc <= ~r_osc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign osc_o = r_osc;

endmodule

// File: rtl/min_max_ctrl.sv
// Controller for the min/max LED bar: live registers, shadow-register edit
// sessions with atomic validated commit, and the datapath command bus.
module min_max_ctrl
  import min_max_pkg::*;
#(
  parameter int VALSIZE = 4,
  parameter int OSC_DIV = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         mode_i,
  input  logic               edit_i,
  input  logic [1:0]         sel_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [1:0]         com_o,
  output logic [VALSIZE-1:0] min_o,
  output logic [VALSIZE-1:0] max_o,
  output logic [VALSIZE-1:0] val_o,
  output logic               osc_o,
  output logic               err_o
);

  localparam logic [VALSIZE-1:0] VTOP = '1;

  ctrl_state_t        r_state;
  com_t               r_com;
  logic [VALSIZE-1:0] r_min, r_max, r_val, r_valOut;
  logic [VALSIZE-1:0] r_shMin, r_shMax, r_shVal;
  logic               r_err;
  logic               r_editPrev;

  sel_t               w_sel;
  logic               w_editRise;
  logic               w_commitOk;
  logic [VALSIZE-1:0] w_runVal;
  logic [VALSIZE-1:0] w_editVal, w_editMin, w_editMax;
  logic [VALSIZE-1:0] w_editShown, w_entryShown, w_clampVal;

  // Saturating single step; simultaneous inc and dec cancel out.
  function automatic logic [VALSIZE-1:0] stepSat(
    input logic [VALSIZE-1:0] v,
    input logic [VALSIZE-1:0] lo,
    input logic [VALSIZE-1:0] hi,
    input logic               up,
    input logic               down
  );
    logic [VALSIZE-1:0] res;
    res = v;
    if (up && !down && v < hi)       res = v + 1'b1;
    else if (down && !up && v > lo)  res = v - 1'b1;
    return res;
  endfunction

  always_comb begin
    w_sel      = sel_t'(sel_i);
    w_editRise = edit_i & ~r_editPrev;
    w_runVal   = stepSat(r_val, r_min, r_max, inc_i, dec_i);

    w_editVal = r_shVal;
    w_editMin = r_shMin;
    w_editMax = r_shMax;
    unique case (w_sel)
      SEL_VAL:  w_editVal = stepSat(r_shVal, '0, VTOP, inc_i, dec_i);
      SEL_MIN:  w_editMin = stepSat(r_shMin, '0, VTOP, inc_i, dec_i);
      SEL_MAX:  w_editMax = stepSat(r_shMax, '0, VTOP, inc_i, dec_i);
      default:  ;
    endcase

    unique case (w_sel)
      SEL_MIN: begin
        w_editShown  = w_editMin;
        w_entryShown = r_min;
      end
      SEL_MAX: begin
        w_editShown  = w_editMax;
        w_entryShown = r_max;
      end
      default: begin
        w_editShown  = w_editVal;
        w_entryShown = w_runVal;
      end
    endcase

    w_commitOk = (r_shMin <= r_shMax);
    if (r_shVal < r_shMin)      w_clampVal = r_shMin;
    else if (r_shVal > r_shMax) w_clampVal = r_shMax;
    else                        w_clampVal = r_shVal;
  end

  // Shadows load on EDIT entry so an edit always starts from the live values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= RUN;
      r_com      <= COM_OFF;
      r_min      <= '0;
      r_max      <= VTOP;
      r_val      <= '0;
      r_valOut   <= '0;
      r_shMin    <= '0;
      r_shMax    <= VTOP;
      r_shVal    <= '0;
      r_err      <= 1'b0;
      r_editPrev <= 1'b0;
    end else begin
      r_editPrev <= edit_i;
      unique case (r_state)
        RUN: begin
          r_val <= w_runVal;
          if (w_editRise) begin
            r_state  <= EDIT;
            r_com    <= COM_LINEAR;
            r_shVal  <= w_runVal;
            r_shMin  <= r_min;
            r_shMax  <= r_max;
            r_valOut <= w_entryShown;
          end else begin
            r_com    <= mode_i;
            r_valOut <= w_runVal;
          end
        end
        EDIT: begin
          r_shVal  <= w_editVal;
          r_shMin  <= w_editMin;
          r_shMax  <= w_editMax;
          r_com    <= COM_LINEAR;
          r_valOut <= w_editShown;
          if (!edit_i) r_state <= COMMIT;
        end
        COMMIT: begin
          // An inverted range is rejected whole; live values never go inconsistent.
          if (w_commitOk) begin
            r_min    <= r_shMin;
            r_max    <= r_shMax;
            r_val    <= w_clampVal;
            r_shVal  <= w_clampVal;
            r_valOut <= w_clampVal;
            r_err    <= 1'b0;
          end else begin
            r_shVal  <= r_val;
            r_shMin  <= r_min;
            r_shMax  <= r_max;
            r_valOut <= r_val;
            r_err    <= 1'b1;
          end
          r_com   <= mode_i;
          r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  osc_gen #(.DIV(OSC_DIV)) u_osc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .osc_o  (osc_o)
  );

  assign com_o = r_com;
  assign min_o = r_min;
  assign max_o = r_max;
  assign val_o = r_valOut;
  assign err_o = r_err;

endmodule

// File: tb/tb_min_max_ctrl.sv
// Scoreboard bench for min_max_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_min_max_ctrl;

  localparam int VS  = 4;
  localparam int DIV = 4;
  localparam int TOP = (1 << VS) - 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          edit = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic          inc = 1'b0;
  logic          dec = 1'b0;
  logic [1:0]    com;
  logic [VS-1:0] mn, mx, vl;
  logic          osc, err;

  min_max_ctrl #(.VALSIZE(VS), .OSC_DIV(DIV)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .mode_i (mode),
    .edit_i (edit),
    .sel_i  (sel),
    .inc_i  (inc),
    .dec_i  (dec),
    .com_o  (com),
    .min_o  (mn),
    .max_o  (mx),
    .val_o  (vl),
    .osc_o  (osc),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    com;
    logic [VS-1:0] mn;
    logic [VS-1:0] mx;
    logic [VS-1:0] vl;
    logic          osc;
    logic          err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Model state: phase 0 running, 1 editing, 2 committing.
  int phase, mMin, mMax, mVal, mOut, sMin, sMax, sVal, mCom, mErr, nEdges;
  bit prevEdit;

  bit         curR = 1'b0;
  logic [1:0] curMode = 2'b00;
  bit         curEdit = 1'b0;
  logic [1:0] curSel = 2'b00;

  function automatic int step(input int v, input int lo, input int hi, input bit up, input bit down);
    if (up && !down)      return (v + 1 > hi) ? v : v + 1;
    else if (down && !up) return (v - 1 < lo) ? v : v - 1;
    return v;
  endfunction

  function automatic int shown(input int s, input int vv, input int lo, input int hi);
    if (s == 1) return lo;
    if (s == 2) return hi;
    return vv;
  endfunction

  task automatic modelEdge(input bit r, input int m, input bit e, input int s, input bit i, input bit d);
    if (!r) begin
      phase = 0; mMin = 0; mMax = TOP; mVal = 0; mOut = 0;
      sMin = 0; sMax = TOP; sVal = 0; mCom = 2; mErr = 0; nEdges = 0; prevEdit = 1'b0;
      return;
    end
    nEdges++;
    case (phase)
      0: begin
        mVal = step(mVal, mMin, mMax, i, d);
        if (e && !prevEdit) begin
          phase = 1; sVal = mVal; sMin = mMin; sMax = mMax; mCom = 1;
          mOut = shown(s, sVal, sMin, sMax);
        end else begin
          mCom = m; mOut = mVal;
        end
      end
      1: begin
        if (s == 0) sVal = step(sVal, 0, TOP, i, d);
        if (s == 1) sMin = step(sMin, 0, TOP, i, d);
        if (s == 2) sMax = step(sMax, 0, TOP, i, d);
        mCom = 1;
        mOut = shown(s, sVal, sMin, sMax);
        if (!e) phase = 2;
      end
      default: begin
        if (sMin <= sMax) begin
          mMin = sMin; mMax = sMax;
          mVal = (sVal < sMin) ? sMin : ((sVal > sMax) ? sMax : sVal);
          sVal = mVal; mErr = 0;
        end else begin
          sVal = mVal; sMin = mMin; sMax = mMax; mErr = 1;
        end
        mOut = mVal; mCom = m; phase = 0;
      end
    endcase
    prevEdit = e;
  endtask

  task automatic applyStimulus(input bit r, input logic [1:0] m, input bit e,
                               input logic [1:0] s, input bit i, input bit d);
    exp_t x;
    rstN = r; mode = m; edit = e; sel = s; inc = i; dec = d;
    modelEdge(r, int'(m), e, int'(s), i, d);
    x.com = 2'(mCom); x.mn = VS'(mMin); x.mx = VS'(mMax); x.vl = VS'(mOut);
    x.osc = ((nEdges / DIV) % 2) == 1; x.err = (mErr != 0);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit i, input bit d);
    applyStimulus(curR, curMode, curEdit, curSel, i, d);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checkOutput("com_o", int'(com), int'(x.com));
      checkOutput("min_o", int'(mn),  int'(x.mn));
      checkOutput("max_o", int'(mx),  int'(x.mx));
      checkOutput("val_o", int'(vl),  int'(x.vl));
      checkOutput("osc_o", int'(osc), int'(x.osc));
      checkOutput("err_o", int'(err), int'(x.err));
    end
  end

  initial begin
    curR = 1'b0;
    repeat (2) tick(0, 0);
    curR = 1'b1;
    repeat (10) tick(0, 0);

    repeat (20) tick(1, 0);
    repeat (20) tick(0, 1);
    tick(1, 1);
    repeat (12) tick(1, 0);

    curEdit = 1'b1; curSel = 2'b01;
    tick(0, 0);
    repeat (5) tick(1, 0);
    curSel = 2'b10;
    repeat (7) tick(0, 1);
    curEdit = 1'b0;
    repeat (3) tick(0, 0);

    curEdit = 1'b1; curSel = 2'b01;
    tick(0, 0);
    repeat (5) tick(1, 0);
    curEdit = 1'b0;
    repeat (3) tick(0, 0);

    curEdit = 1'b1;
    repeat (2) tick(0, 0);
    curEdit = 1'b0;
    repeat (3) tick(0, 0);

    curEdit = 1'b1; curSel = 2'b01;
    tick(0, 0);
    repeat (4) tick(1, 0);
    curR = 1'b0;
    tick(0, 0);
    curR = 1'b1; curEdit = 1'b0;
    repeat (2) tick(0, 0);
    curEdit = 1'b1;
    repeat (2) tick(0, 0);
    curEdit = 1'b0;
    repeat (3) tick(0, 0);

    curEdit = 1'b1; curSel = 2'b11; curMode = 2'b00;
    tick(0, 0);
    curMode = 2'b11;
    repeat (3) tick(1, 0);
    curEdit = 1'b0;
    repeat (4) tick(0, 0);

    for (int k = 0; k < 1500; k++) begin
      curR = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) curEdit = ~curEdit;
      if ($urandom_range(0, 5) == 0) curSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) curMode = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    curR = 1'b1;

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d expected=0 pending entries", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/min_max_ctrl.md
# min_max_ctrl

Sequencing and configuration controller for the `min_max_top` LED-bar datapath. It holds the live min/max/value registers and edits them from inc/dec button pulses through shadow registers. Edits are committed atomically, and only when min ≤ max. It also generates the osc blink signal from a programmable divider and drives the datapath command bus. All datapath-facing outputs are registered; the block sits between the board user inputs and `min_max_top`.

## Interface
Parameters:
- VALSIZE, 4, width of min/max/value; the LED bar has 2**VALSIZE positions.
- OSC_DIV, 8, clock cycles per osc half-period; must be ≥ 1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous active-low reset.
- mode_i  in  2  requested datapath command while running: 00 range, 01 linear, 10 off, 11 all-on.
- edit_i  in  1  level; high = edit session.
- sel_i  in  2  edit target: 00 value, 01 min, 10 max, 11 none.
- inc_i  in  1  single-cycle increment pulse.
- dec_i  in  1  single-cycle decrement pulse.
- com_o  out  2  command to datapath.
- min_o  out  VALSIZE  live min.
- max_o  out  VALSIZE  live max.
- val_o  out  VALSIZE  value to display.
- osc_o  out  1  blink signal.
- err_o  out  1  sticky flag: last commit rejected.

## Operation
- Reset values: state RUN; com_o=10; min_o=0; max_o=2**VALSIZE-1; val_o=0; osc_o=0; err_o=0; shadows=live; osc counter=0.
- FSM has three states:
  - RUN: com_o=mode_i (registered). inc/dec act on the live value, saturating at [min_o, max_o]. `edit_i` rising moves to EDIT.
  - EDIT: shadows are loaded from live on the entry cycle. inc/dec act on the shadow chosen by sel_i, saturating at 0 and 2**VALSIZE-1; sel=11 ignores pulses. com_o=01 and val_o=the selected shadow (value shadow when sel=11). min_o/max_o remain live. `edit_i` low moves to COMMIT.
  - COMMIT (one cycle): if shadow_min ≤ shadow_max, copy shadows to live, clamp the live value into the new [min,max], and clear err_o. Otherwise keep live unchanged, reload shadows from live, and set err_o. Always moves to RUN.
- inc and dec asserted in the same cycle: no change.
- At saturation, a pulse is ignored silently; there is no wrap-around.
- mode_i changes during EDIT are ignored until RUN.
- Osc generator is free-running in every state:
  - counter 0..OSC_DIV-1;
  - osc_o toggles on the cycle the counter wraps, so the period is 2·OSC_DIV cycles.

## Timing
- Every output is registered: a change on inputs sampled at edge N is visible after edge N+1.
- edit_i rising sampled at edge N puts the FSM in EDIT after edge N+1.
- edit_i falling at edge N gives COMMIT after N+1 and RUN after N+2. New live values appear with the COMMIT→RUN transition.
- Pulses arriving during COMMIT are dropped.
- Reset mid-EDIT discards shadows and returns all outputs to their reset values after the reset edge.
- First osc_o rising edge comes OSC_DIV cycles after reset release.

## Structure
- Package `min_max_pkg`:
  - typedef `com_t` (logic[1:0]) with constants COM_RANGE=00, COM_LINEAR=01, COM_OFF=10, COM_ON=11;
  - enum `ctrl_state_t` {RUN, EDIT, COMMIT};
  - enum `sel_t`.
- Sub-module `osc_gen`, parameter DIV: clk_i, rst_ni, osc_o, the divider counter and toggle flop.
- Everything else (FSM, shadow/live registers, saturating update) lives in `min_max_ctrl`.

## Test plan
- Reset, VALSIZE=4, OSC_DIV=4 → com_o=10, min_o=0, max_o=15, val_o=0, err_o=0; osc_o rises 4 cycles after release, then toggles every 4 cycles.
- RUN, mode=00, min=0, max=15, 20 inc pulses → val_o stops at 15; 20 dec pulses → val_o stops at 0; inc+dec in the same cycle → val_o unchanged.
- EDIT sel=01, 5 inc, then sel=10, 7 dec, release → during EDIT com_o=01 and val_o shows the shadow; after COMMIT min_o=5, max_o=8, and a prior val_o of 12 is clamped to 8; err_o=0.
- EDIT sel=01 raised to 10 with max=8, release → commit rejected: min_o=5 and max_o=8 unchanged, err_o=1; next valid commit clears err_o.
- Reset asserted mid-EDIT with edited shadow min=9 → after the reset edge all outputs are at reset values; the next EDIT entry shows shadow min=0.
- mode_i changed 00→11 during EDIT → com_o stays 01 until RUN, then follows 11 one cycle later.
